// File: rtl/cp_load_sequencer_pkg.sv
// Shared definitions for the control-plane load path: sequencer states,
// header field layout and the defaults shared with control_plane.
package cp_pkg;
    localparam int PHIT_SIZE    = 512;
    localparam int DWIDTH_RFADD = 8;
    localparam int TOTAL_W      = 16;

    // Header field positions, in units of dwidth_RFadd-wide fields
    localparam int HDR_S_IDX = 0;
    localparam int HDR_C_IDX = 1;
    localparam int HDR_I_IDX = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        START = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4,
        DRAIN = 3'd5
    } state_t;
endpackage

// File: rtl/cp_load_sequencer_buf.sv
// Burst buffer: write-then-read RAM with per-burst pointer clear and a
// registered read port that returns zero whenever no read was issued.
module cp_burst_buf #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (we) wptr <= wptr + AW'(1);
            if (re) rptr <= rptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wptr] <= wdata;
    end

    // Zero when idle so the loader sees a clean bus outside the burst
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[rptr];
        else         rdata <= '0;
    end
endmodule

// File: rtl/cp_load_sequencer.sv
// Buffers a host header + payload burst, then replays it to control_plane as
// start_loader followed by back-to-back wr_data words.
module cp_load_sequencer
    import cp_pkg::*;
#(
    parameter int phit_size    = PHIT_SIZE,
    parameter int dwidth_RFadd = DWIDTH_RFADD,
    parameter int NUM_STAGE    = 6,
    parameter int DEPTH        = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [phit_size-1:0]    s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    start_loader,
    output logic [phit_size-1:0]    wr_data,
    output logic [dwidth_RFadd-1:0] num_entry_config_table,
    output logic [dwidth_RFadd-1:0] num_entry_inbound,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    state_t               state, state_nxt;
    logic [TOTAL_W-1:0]   total, cnt, hdr_total;
    logic [dwidth_RFadd-1:0] hdr_s, hdr_c, hdr_i;
    logic                 ready_c, hdr_acc, buf_we, buf_re, last, cnt_step, too_big;

    assign hdr_s = s_data[HDR_S_IDX*dwidth_RFadd +: dwidth_RFadd];
    assign hdr_c = s_data[HDR_C_IDX*dwidth_RFadd +: dwidth_RFadd];
    assign hdr_i = s_data[HDR_I_IDX*dwidth_RFadd +: dwidth_RFadd];

    // S + 2*NUM_STAGE*C + I, widened first so nothing overflows
    assign hdr_total = TOTAL_W'(hdr_s) + TOTAL_W'(2*NUM_STAGE) * TOTAL_W'(hdr_c) + TOTAL_W'(hdr_i);
    assign too_big   = int'(hdr_total) > DEPTH;
    assign last      = (cnt == total - TOTAL_W'(1));

    always_comb begin
        state_nxt    = state;
        ready_c      = 1'b0;
        start_loader = 1'b0;
        done         = 1'b0;
        hdr_acc      = 1'b0;
        buf_we       = 1'b0;
        buf_re       = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (s_valid) begin
                    hdr_acc = 1'b1;
                    if (hdr_total == '0) state_nxt = DONE;
                    else if (too_big)    state_nxt = DRAIN;
                    else                 state_nxt = FILL;
                end
            end
            FILL: begin
                ready_c = 1'b1;
                buf_we  = s_valid;
                if (s_valid && last) state_nxt = START;
            end
            START: begin
                start_loader = 1'b1;
                buf_re       = 1'b1;
                state_nxt    = SEND;
            end
            SEND: begin
                // Prefetch word k+1 while word k is on the bus
                buf_re = !last;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            DRAIN: begin
                ready_c = 1'b1;
                if (s_valid && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cnt_step = ((state == FILL || state == DRAIN) && s_valid) || (state == SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            cnt                    <= '0;
            total                  <= '0;
            num_entry_config_table <= '0;
            num_entry_inbound      <= '0;
            err                    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hdr_acc) begin
                total                  <= hdr_total;
                num_entry_config_table <= hdr_c;
                num_entry_inbound      <= hdr_i;
                err                    <= too_big;
                cnt                    <= '0;
            end else if (cnt_step) begin
                cnt <= last ? '0 : cnt + TOTAL_W'(1);
            end
        end
    end

    assign s_ready = ready_c & ~rst;
    assign busy    = (state != IDLE);

    cp_burst_buf #(
        .WIDTH (phit_size),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (hdr_acc),
        .we    (buf_we),
        .wdata (s_data),
        .re    (buf_re),
        .rdata (wr_data)
    );
endmodule

// File: tb/tb_cp_load_sequencer.sv
// Bench for cp_load_sequencer: table of bursts, random bursts against a queue
// model of the replay, and hand-written reset-abort sequence.
module tb_cp_load_sequencer;
    localparam int PW    = 512;
    localparam int DW    = 8;
    localparam int NS    = 6;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] s_data;
    logic          s_valid;
    logic          s_ready, start_loader, busy, done, err;
    logic [PW-1:0] wr_data;
    logic [DW-1:0] num_entry_config_table, num_entry_inbound;

    cp_load_sequencer #(
        .phit_size(PW), .dwidth_RFadd(DW), .NUM_STAGE(NS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .start_loader(start_loader), .wr_data(wr_data),
        .num_entry_config_table(num_entry_config_table),
        .num_entry_inbound(num_entry_inbound),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int s, c, i;
        int stall;   // 0 none, 1 every other cycle, 2 random
        int total;
        bit err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] rand_word();
        logic [PW-1:0] w;
        for (int j = 0; j < PW/32; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    // Drives header then payload; checks the replay against a queue of accepted words
    task automatic run_burst(input int s, input int c, input int i, input int stall,
                             input int total, input bit exp_err);
        logic [PW-1:0] hdr, w;
        logic [PW-1:0] q[$];
        bit bad;
        hdr = rand_word();
        hdr[7:0]   = 8'(s);
        hdr[15:8]  = 8'(c);
        hdr[23:16] = 8'(i);
        s_data  = hdr;
        s_valid = 1'b1;
        chk("idle_ready", s_ready, 1);
        chk("idle_busy", busy, 0);
        tick();
        chk("hdr_err", err, exp_err);
        chk("hdr_num_cfg", num_entry_config_table, c);
        chk("hdr_num_in", num_entry_inbound, i);
        bad = 1'b0;
        if (total == 0) begin
            s_valid = 1'b0;
            chk("zero_done", done, 1);
            chk("zero_nostart", start_loader, 0);
            tick();
            chk("zero_idle", busy, 0);
            chk("zero_done_clr", done, 0);
        end else begin
            for (int k = 0; k < total; k++) begin
                if (stall == 1 || (stall == 2 && $urandom_range(0, 1) == 1)) begin
                    s_valid = 1'b0;
                    s_data  = rand_word();
                    tick();
                    if (start_loader || done || !s_ready) bad = 1'b1;
                end
                w = (stall == 2) ? rand_word() : PW'(k + 1);
                s_valid = 1'b1;
                s_data  = w;
                if (!exp_err) q.push_back(w);
                tick();
                if (k < total - 1 && (start_loader || done || !s_ready)) bad = 1'b1;
            end
            s_valid = 1'b0;
            chk("fill_quiet", bad, 0);
            if (exp_err) begin
                chk("drain_idle", busy, 0);
                chk("drain_err_held", err, 1);
                chk("drain_nostart", start_loader, 0);
            end else begin
                chk("start_pulse", start_loader, 1);
                chk("start_ready", s_ready, 0);
                tick();
                for (int k = 0; k < total; k++) begin
                    chk($sformatf("wr_data[%0d]", k), wr_data, q[k]);
                    if (start_loader || done || s_ready) bad = 1'b1;
                    tick();
                end
                chk("send_quiet", bad, 0);
                chk("done_pulse", done, 1);
                chk("done_wr_zero", wr_data, 0);
                tick();
                chk("after_done", done, 0);
                chk("after_busy", busy, 0);
                chk("num_cfg_held", num_entry_config_table, c);
                chk("num_in_held", num_entry_inbound, i);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2, 2, 16, 0, 42, 1'b0};
        vecs[1] = '{2, 2, 16, 1, 42, 1'b0};
        vecs[2] = '{0, 0, 0, 0, 0, 1'b0};
        vecs[3] = '{255, 255, 255, 0, 3570, 1'b1};
        vecs[4] = '{0, 1, 8, 0, 20, 1'b0};
        vecs[5] = '{20, 0, 0, 2, 20, 1'b0};
        vecs[6] = '{1, 0, 255, 0, 256, 1'b0};
        vecs[7] = '{2, 0, 255, 0, 257, 1'b1};
        vecs[8] = '{0, 0, 1, 0, 1, 1'b0};
        vecs[9] = '{3, 1, 1, 2, 16, 1'b0};

        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_start", start_loader, 0);
        chk("rst_wr", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cfg", num_entry_config_table, 0);
        chk("rst_in", num_entry_inbound, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[v])
            run_burst(vecs[v].s, vecs[v].c, vecs[v].i, vecs[v].stall, vecs[v].total, vecs[v].err);

        for (int r = 0; r < 12; r++) begin
            int s, c, i, tot;
            s   = $urandom_range(0, 60);
            c   = $urandom_range(0, 20);
            i   = $urandom_range(0, 60);
            tot = s + 2 * NS * c + i;
            run_burst(s, c, i, 2, tot, tot > DEPTH);
        end

        // Abort in the 10th SEND cycle of a 42-word burst
        s_data = '0; s_data[23:0] = 24'h10_02_02; s_valid = 1'b1;
        tick();
        for (int k = 0; k < 42; k++) begin
            s_data = PW'(k + 1);
            tick();
        end
        s_valid = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) tick();
        chk("abort_pre_word", wr_data, 10);
        rst = 1'b1;
        chk("abort_rst_ready", s_ready, 0);
        tick();
        rst = 1'b0;
        chk("abort_wr_zero", wr_data, 0);
        chk("abort_idle", busy, 0);
        chk("abort_no_done", done, 0);
        chk("abort_cfg_zero", num_entry_config_table, 0);
        tick();
        chk("abort_still_quiet", done, 0);
        run_burst(0, 0, 4, 0, 4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
